ahb_master_initiator: RTL and testbench
=======================================

Name: ahb_master_initiator

Overview:
- AHB initiator that turns simple command requests into AHB transfers toward the bridge's AHB slave interface.
- Supports single and INCR bursts of 1–16 word beats, honours hreadyin wait states and hresp errors, and returns read data.
- Sits between a test or DMA command source and the AHB-to-APB bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; transfers are always full-word (hsize = 3'b010).
- TIMEOUT, 16, maximum wait-state cycles per data phase; used only with the optional feature.

Ports:
- hclk  in  1  clock.
- hresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  start address, word aligned.
- cmd_len  in  4  number of beats minus 1.
- wr_data  in  DATA_W  write data for the current beat.
- wr_data_req  out  1  one-cycle pulse: wr_data consumed, present the next word.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse per read beat.
- done  out  1  one-cycle pulse at command end.
- done_err  out  1  qualifies done; command ended on error or timeout.
- haddr  out  ADDR_W  AHB address.
- htrans  out  2  AHB transfer type.
- hwrite  out  1  AHB direction.
- hsize  out  3  fixed 3'b010.
- hburst  out  3  3'b000 SINGLE when cmd_len = 0, else 3'b001 INCR.
- hwdata  out  DATA_W  write data.
- hreadyin  in  1  slave hreadyout.
- hresp  in  2  slave response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- hrdata  in  DATA_W  read data.

Behaviour:
- Reset values: htrans = IDLE, haddr = 0, hwdata = 0, hwrite = 0, hburst = 0, rd_data = 0, all pulses 0, cmd_ready = 1. Reset is asynchronous and may occur mid-burst; the command in flight is dropped with no done pulse.
- All AHB outputs are registered.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid, latch the command and go to ADDR.
  - ADDR: drive NONSEQ at cmd_addr in the cycle after acceptance.
  - BURST: address phase of beat k overlaps data phase of beat k-1.
  - LAST: final data phase; htrans = IDLE.
  - ERR: error cancel, described below.
- Address phase completes on a rising edge with hreadyin = 1.
  - Next cycle: haddr += 4, htrans = SEQ, beat counter decrements.
  - After the last address is accepted: htrans = IDLE, go to LAST.
- 1 KB boundary: if the incremented address has bits [9:0] = 0, that beat is issued as NONSEQ instead of SEQ. The address still increments.
- Write data:
  - wr_data is sampled, and wr_data_req pulses, on the edge where that beat's address phase is accepted.
  - hwdata holds the value through the whole data phase, including wait states.
- Read data: on the edge where a read data phase completes with OKAY, rd_data <= hrdata and rd_valid pulses in the following cycle.
- Wait states (hreadyin = 0): haddr, htrans, hwrite and hwdata hold.
- Completion: done pulses in the cycle after the final data phase completes, then the block returns to IDLE. It accepts a new command no earlier than that IDLE cycle; no back-to-back overlap.
- Error handling (hresp != OKAY; RETRY and SPLIT are treated as ERROR):
  - First response cycle (hreadyin = 0): next cycle htrans = IDLE and any pending address phase is cancelled.
  - Second response cycle (hreadyin = 1): done = done_err = 1 in the next cycle.
  - Remaining beats are discarded and no rd_valid is issued for the errored beat.
- cmd_len = 15: 16 beats.
- The beat counter saturates at 0 and never wraps.

Optional Feature:
- AHB_MASTER_TIMEOUT_EN defined: a counter runs while hreadyin = 0 within a data phase. When it reaches TIMEOUT:
  - Force htrans = IDLE and abandon the command.
  - Pulse done and done_err.
  - Return to IDLE.
- Not defined: the block waits indefinitely; no counter logic is present.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ = 00/01/10/11.
  - HRESP_OKAY/ERROR/RETRY/SPLIT = 00/01/10/11.
  - HBURST_SINGLE/INCR, HSIZE_WORD.
  - State-encoding constants.
- One sub-module, ahb_addr_gen: beat counter, address increment and 1 KB boundary detection. It outputs next_addr, next_is_nonseq and last_beat.

Test Plan:
- Single write: cmd_addr = 32'h80000010, cmd_len = 0, wr_data = 32'h12345678, hreadyin = 1 → NONSEQ one cycle after acceptance, hwdata = 32'h12345678 next cycle, done two cycles later, done_err = 0.
- 4-beat read: cmd_addr = 32'h84000020, hrdata = 32'hCAFE, 2 wait states on beat 2 → addresses 20/24/28/2C issued as NONSEQ,SEQ,SEQ,SEQ; outputs held during the waits; four rd_valid pulses with rd_data = 32'hCAFE.
- 1 KB crossing: cmd_addr = 32'h800003F8, cmd_len = 3, write → htrans NONSEQ,SEQ,NONSEQ,SEQ at 3F8/3FC/400/404; four wr_data_req pulses.
- Error: hresp = 01 for two cycles on beat 2 of a 4-beat write → htrans = IDLE in the second error cycle, done and done_err pulse, no further beats.
- Reset mid-burst: hresetn low during beat 3 → all outputs at reset values immediately; after release cmd_ready = 1 and no done pulse.
- AHB_MASTER_TIMEOUT_EN with TIMEOUT = 16, hreadyin held low → done_err pulses after 16 wait cycles and htrans = IDLE.

Source files
------------

// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_pkg                                                              |
// | Shared AHB encodings, FSM state encoding and address helpers for     |
// | the AHB master initiator.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_BURST = 3'd2,
        ST_LAST  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // An INCR burst may not carry SEQ across a 1 KB page; the first beat
    // of a new page restarts with NONSEQ.
    function automatic logic is_1kb_start(input logic [9:0] addr_lo);
        return (addr_lo == 10'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_addr_gen                                                         |
// | Beat counter, word address increment and 1 KB boundary detection.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [3:0]        len_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] cur_addr_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              next_is_nonseq_o,
    output logic              last_beat_o
);

    // Addresses still to be issued after the one currently on the bus.
    logic [3:0] count_q;

    assign next_addr_o      = cur_addr_i + ADDR_W'(4);
    assign next_is_nonseq_o = is_1kb_start(next_addr_o[9:0]);
    assign last_beat_o      = (count_q == 4'd0);

    // Load the beat count on command accept, count down per accepted address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 4'd0;
        end else if (load_i) begin
            count_q <= len_i;
        end else if (advance_i) begin
            count_q <= (count_q != 4'd0) ? count_q - 4'd1 : 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_master_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_master_initiator                                                 |
// | Turns simple command requests into AHB SINGLE/INCR transfers with    |
// | wait-state, error and read-data handling.                            |
// | Optional: AHB_MASTER_TIMEOUT_EN adds a per-data-phase wait timeout.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_master_initiator
    import ahb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_data_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              done_err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hreadyin,
    input  logic [1:0]        hresp,
    input  logic [DATA_W-1:0] hrdata
);

    state_e            state_q;
    logic [ADDR_W-1:0] haddr_q;
    logic [1:0]        htrans_q;
    logic              hwrite_q;
    logic [2:0]        hburst_q;
    logic [DATA_W-1:0] hwdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              wr_data_req_q;
    logic              done_q;
    logic              done_err_q;

    logic [ADDR_W-1:0] next_addr;
    logic              next_is_nonseq;
    logic              last_beat;
    logic              addr_load;
    logic              addr_accept;

    // The first address phase has no data phase alongside it, so a slave
    // response is only meaningful from BURST onwards.
    assign addr_load   = (state_q == ST_IDLE) && cmd_valid;
    assign addr_accept = hreadyin && ((state_q == ST_ADDR) ||
                         ((state_q == ST_BURST) && (hresp == HRESP_OKAY)));

    ahb_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i            (hclk),
        .rst_ni           (hresetn),
        .load_i           (addr_load),
        .len_i            (cmd_len),
        .advance_i        (addr_accept && !last_beat),
        .cur_addr_i       (haddr_q),
        .next_addr_o      (next_addr),
        .next_is_nonseq_o (next_is_nonseq),
        .last_beat_o      (last_beat)
    );

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q;
    logic          timeout_hit;
    // Current cycle is the TIMEOUT-th consecutive wait state of a data phase
    assign timeout_hit = (wait_cnt_q == TW'(TIMEOUT - 1));
`endif

    assign cmd_ready   = (state_q == ST_IDLE);
    assign haddr       = haddr_q;
    assign htrans      = htrans_q;
    assign hwrite      = hwrite_q;
    assign hsize       = HSIZE_WORD;
    assign hburst      = hburst_q;
    assign hwdata      = hwdata_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign wr_data_req = wr_data_req_q;
    assign done        = done_q;
    assign done_err    = done_err_q;

    // Transfer FSM; every bus and status output is a register updated here
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q       <= ST_IDLE;
            haddr_q       <= '0;
            htrans_q      <= HTRANS_IDLE;
            hwrite_q      <= 1'b0;
            hburst_q      <= HBURST_SINGLE;
            hwdata_q      <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            wr_data_req_q <= 1'b0;
            done_q        <= 1'b0;
            done_err_q    <= 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
            wait_cnt_q    <= '0;
`endif
        end else begin
            rd_valid_q    <= 1'b0;
            wr_data_req_q <= 1'b0;
            done_q        <= 1'b0;
            done_err_q    <= 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
            wait_cnt_q    <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        haddr_q  <= cmd_addr;
                        htrans_q <= HTRANS_NONSEQ;
                        hwrite_q <= cmd_write;
                        hburst_q <= (cmd_len == 4'd0) ? HBURST_SINGLE : HBURST_INCR;
                        state_q  <= ST_ADDR;
                    end
                end
                ST_ADDR, ST_BURST: begin
                    if ((state_q == ST_BURST) && (hresp != HRESP_OKAY)) begin
                        // Cancel the pending address; finish on the second response cycle
                        htrans_q <= HTRANS_IDLE;
                        if (hreadyin) begin
                            done_q     <= 1'b1;
                            done_err_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end else if (hreadyin) begin
                        if ((state_q == ST_BURST) && !hwrite_q) begin
                            rd_data_q  <= hrdata;
                            rd_valid_q <= 1'b1;
                        end
                        if (hwrite_q) begin
                            hwdata_q      <= wr_data;
                            wr_data_req_q <= 1'b1;
                        end
                        if (last_beat) begin
                            htrans_q <= HTRANS_IDLE;
                            state_q  <= ST_LAST;
                        end else begin
                            haddr_q  <= next_addr;
                            htrans_q <= next_is_nonseq ? HTRANS_NONSEQ : HTRANS_SEQ;
                            state_q  <= ST_BURST;
                        end
                    end
`ifdef AHB_MASTER_TIMEOUT_EN
                    else if (state_q == ST_BURST) begin
                        if (timeout_hit) begin
                            htrans_q   <= HTRANS_IDLE;
                            done_q     <= 1'b1;
                            done_err_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + TW'(1);
                        end
                    end
`endif
                end
                ST_LAST: begin
                    if (hresp != HRESP_OKAY) begin
                        if (hreadyin) begin
                            done_q     <= 1'b1;
                            done_err_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end else if (hreadyin) begin
                        if (!hwrite_q) begin
                            rd_data_q  <= hrdata;
                            rd_valid_q <= 1'b1;
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
`ifdef AHB_MASTER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        done_q     <= 1'b1;
                        done_err_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
                    end
`endif
                end
                ST_ERR: begin
                    if (hreadyin) begin
                        done_q     <= 1'b1;
                        done_err_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    htrans_q <= HTRANS_IDLE;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ahb_master_initiator                                              |
// | Directed, self-checking bench for ahb_master_initiator.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ahb_master_initiator;

    logic        hclk;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_data_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        done_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int          n_vec;
    int          n_miss;
    int          rdv_cnt;
    int          wreq_cnt;
    int          done_cnt;
    logic [31:0] wbase;

    ahb_master_initiator #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wr_data     (wr_data),
        .wr_data_req (wr_data_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .done        (done),
        .done_err    (done_err),
        .haddr       (haddr),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hburst      (hburst),
        .hwdata      (hwdata),
        .hreadyin    (hreadyin),
        .hresp       (hresp),
        .hrdata      (hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [1:0] trans, input logic [31:0] addr);
        check_val({tag, "_htrans"}, {62'd0, htrans}, {62'd0, trans});
        check_val({tag, "_haddr"}, {32'd0, haddr}, {32'd0, addr});
    endtask

    // Advance to the next falling edge, tally pulses and act as write-data source
    task automatic tick();
        @(negedge hclk);
        rdv_cnt  += int'(rd_valid);
        done_cnt += int'(done);
        if (wr_data_req) begin
            wreq_cnt++;
            wr_data = wbase + 32'(wreq_cnt);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns one edge after acceptance
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] len);
        rdv_cnt   = 0;
        wreq_cnt  = 0;
        done_cnt  = 0;
        wr_data   = wbase;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_miss = 0; rdv_cnt = 0; wreq_cnt = 0; done_cnt = 0;
        wbase = 32'h0;
        hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; wr_data = '0; hreadyin = 1'b1; hresp = 2'b00; hrdata = '0;

        // Reset values
        tick(); tick();
        check_bus("rst", 2'b00, 32'h0);
        check_val("rst_hwdata", hwdata, 0);
        check_val("rst_hwrite", hwrite, 0);
        check_val("rst_hburst", hburst, 0);
        check_val("rst_hsize", hsize, 3'b010);
        check_val("rst_rd_data", rd_data, 0);
        check_val("rst_pulses", {rd_valid, done, done_err, wr_data_req}, 4'b0000);
        check_val("rst_cmd_ready", cmd_ready, 1);
        hresetn = 1'b1;
        tick();

        // Single write
        wbase = 32'h12345678;
        issue(1'b1, 32'h80000010, 4'd0);
        check_bus("sw_a0", 2'b10, 32'h80000010);
        check_val("sw_hwrite", hwrite, 1);
        check_val("sw_hburst", hburst, 3'b000);
        check_val("sw_cmd_ready", cmd_ready, 0);
        tick();
        check_val("sw_htrans_idle", htrans, 2'b00);
        check_val("sw_hwdata", hwdata, 32'h12345678);
        check_val("sw_wreq", wr_data_req, 1);
        check_val("sw_done_early", done, 0);
        tick();
        check_val("sw_done", {done, done_err}, 2'b10);
        tick();
        check_val("sw_done_once", done, 0);
        check_val("sw_ready_after", cmd_ready, 1);

        // 4-beat read, two wait states on the second data phase
        hrdata = 32'h0000CAFE;
        issue(1'b0, 32'h84000020, 4'd3);
        check_bus("rd_a0", 2'b10, 32'h84000020);
        check_val("rd_hburst", hburst, 3'b001);
        check_val("rd_hwrite", hwrite, 0);
        tick();
        check_bus("rd_a1", 2'b11, 32'h84000024);
        tick();
        check_bus("rd_a2", 2'b11, 32'h84000028);
        check_val("rd_v0", {rd_valid, rd_data}, {1'b1, 32'h0000CAFE});
        hreadyin = 1'b0;
        tick();
        check_bus("rd_w1", 2'b11, 32'h84000028);
        check_val("rd_w1_v", rd_valid, 0);
        tick();
        check_bus("rd_w2", 2'b11, 32'h84000028);
        hreadyin = 1'b1;
        tick();
        check_bus("rd_a3", 2'b11, 32'h8400002C);
        check_val("rd_v1", rd_valid, 1);
        tick();
        check_val("rd_htrans_idle", htrans, 2'b00);
        tick();
        check_val("rd_done", {done, done_err, rd_valid}, 3'b101);
        check_val("rd_data_last", rd_data, 32'h0000CAFE);
        check_val("rd_valid_count", rdv_cnt, 4);
        tick();

        // 1 KB crossing write
        wbase = 32'hA0000000;
        issue(1'b1, 32'h800003F8, 4'd3);
        check_bus("kb_a0", 2'b10, 32'h800003F8);
        tick();
        check_bus("kb_a1", 2'b11, 32'h800003FC);
        check_val("kb_d0", hwdata, 32'hA0000000);
        tick();
        check_bus("kb_a2", 2'b10, 32'h80000400);
        check_val("kb_d1", hwdata, 32'hA0000001);
        tick();
        check_bus("kb_a3", 2'b11, 32'h80000404);
        check_val("kb_d2", hwdata, 32'hA0000002);
        tick();
        check_val("kb_htrans_idle", htrans, 2'b00);
        check_val("kb_d3", hwdata, 32'hA0000003);
        tick();
        check_val("kb_done", {done, done_err}, 2'b10);
        check_val("kb_wreq_count", wreq_cnt, 4);
        tick();

        // Two-cycle ERROR response on the second beat of a 4-beat write
        wbase = 32'hB0000000;
        issue(1'b1, 32'h80001000, 4'd3);
        check_bus("er_a0", 2'b10, 32'h80001000);
        tick();
        check_bus("er_a1", 2'b11, 32'h80001004);
        tick();
        check_bus("er_a2", 2'b11, 32'h80001008);
        check_val("er_d1", hwdata, 32'hB0000001);
        hresp = 2'b01; hreadyin = 1'b0;
        tick();
        check_val("er_htrans_idle", htrans, 2'b00);
        check_val("er_done_early", done, 0);
        hreadyin = 1'b1;
        tick();
        check_val("er_done", {done, done_err}, 2'b11);
        check_val("er_htrans", htrans, 2'b00);
        hresp = 2'b00;
        tick();
        check_val("er_after", {done, cmd_ready, htrans}, 4'b0100);
        check_val("er_wreq_count", wreq_cnt, 2);
        check_val("er_done_count", done_cnt, 1);

        // Asynchronous reset during beat 3 of a read burst
        hrdata = 32'h5555AAAA;
        wbase = 32'h0;
        issue(1'b0, 32'h80002000, 4'd3);
        tick();
        tick();
        check_bus("rs_a2", 2'b11, 32'h80002008);
        check_val("rs_rd_data_pre", rd_data, 32'h5555AAAA);
        hresetn = 1'b0;
        #1;
        check_bus("rs_now", 2'b00, 32'h0);
        check_val("rs_rd_data", rd_data, 0);
        check_val("rs_pulses", {rd_valid, done, done_err, wr_data_req}, 4'b0000);
        check_val("rs_hburst", hburst, 0);
        check_val("rs_cmd_ready", cmd_ready, 1);
        tick(); tick();
        hresetn = 1'b1;
        done_cnt = 0;
        repeat (4) tick();
        check_val("rs_no_done", done_cnt, 0);
        check_val("rs_idle", {cmd_ready, htrans}, 3'b100);

        // Fresh single read after the reset
        hrdata = 32'h00000F0F;
        issue(1'b0, 32'h80000100, 4'd0);
        check_bus("pr_a0", 2'b10, 32'h80000100);
        tick();
        tick();
        check_val("pr_done", {done, done_err, rd_valid}, 3'b101);
        check_val("pr_rd_data", rd_data, 32'h00000F0F);
        tick();

`ifdef AHB_MASTER_TIMEOUT_EN
        // Data phase stalled indefinitely
        hrdata = 32'h0;
        issue(1'b0, 32'h80003000, 4'd0);
        check_bus("to_a0", 2'b10, 32'h80003000);
        tick();
        hreadyin = 1'b0;
        repeat (15) tick();
        check_val("to_no_done_early", done_cnt, 0);
        tick();
        check_val("to_done", {done, done_err}, 2'b11);
        check_val("to_htrans", htrans, 2'b00);
        hreadyin = 1'b1;
        tick();
        check_val("to_ready", cmd_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
